// File: rtl/tt_sweep_ctrl_if.sv
// Vector/result bus between the sweep controller and the logic blocks under
// test. The controller (master) drives the vector and ROM address; the DDNF
// and DKNF implementations plus the table ROM (slave side) answer on it.
interface tt_sweep_ctrl_if #(
  parameter int N_IN  = 9,
  parameter int N_OUT = 4
) ();

  logic [N_IN-1:0]  o_x;         // vector to both implementations
  logic [N_IN-1:0]  o_tab_addr;  // table ROM address, mirrors o_x
  logic [N_OUT-1:0] i_tab_data;  // ROM word, one cycle after the address
  logic [N_OUT-1:0] i_y_ddnf;    // DDNF implementation output
  logic [N_OUT-1:0] i_y_dknf;    // DKNF implementation output

  modport master (
    output o_x,
    output o_tab_addr,
    input  i_tab_data,
    input  i_y_ddnf,
    input  i_y_dknf
  );

  modport slave (
    input  o_x,
    input  o_tab_addr,
    output i_tab_data,
    output i_y_ddnf,
    output i_y_dknf
  );

endinterface

// File: rtl/tt_sweep_ctrl.sv
// Self-check sequencer for the truth-table logic blocks. Walks every input
// vector, lets the implementations and the synchronous table ROM settle,
// compares both implementations against the golden word and keeps
// mismatch statistics that persist until the next accepted start.
module tt_sweep_ctrl #(
  parameter int N_IN   = 9,
  parameter int N_OUT  = 4,
  parameter int SETTLE = 1   // 1..15; at least 1 to cover the ROM latency
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_abort,
  tt_sweep_ctrl_if.master     bus,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic [N_IN:0]       o_err_count,
  output logic [1:0]          o_err_flags,
  output logic                o_first_err_valid,
  output logic [N_IN-1:0]     o_first_err_idx
);

  localparam logic [N_IN-1:0] LAST_IDX    = '1;
  localparam logic [N_IN-1:0] IDX_ONE     = 1;
  localparam logic [N_IN:0]   ERR_ONE     = 1;
  localparam logic [N_IN:0]   ERR_MAX     = {1'b1, {N_IN{1'b0}}};
  localparam logic [3:0]      SETTLE_INIT = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [N_IN-1:0]   r_idx;
  logic [3:0]        r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [N_IN:0]     r_err_count;
  logic [1:0]        r_err_flags;
  logic              r_first_err_valid;
  logic [N_IN-1:0]   r_first_err_idx;

  logic              w_ddnf_bad;
  logic              w_dknf_bad;
  logic              w_any_bad;

  assign w_ddnf_bad = (bus.i_y_ddnf != bus.i_tab_data);
  assign w_dknf_bad = (bus.i_y_dknf != bus.i_tab_data);
  assign w_any_bad  = w_ddnf_bad | w_dknf_bad;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode: start wins in IDLE, abort exits SETTLE/CHECK.
  always_comb begin
    // NOTE: default first so every path assigns w_next_state; no latch.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next_state = S_SETTLE;
      S_SETTLE: begin
        if (i_abort)                w_next_state = S_IDLE;
        else if (r_cnt == 4'd1)     w_next_state = S_CHECK;
      end
      S_CHECK: begin
        if (i_abort)                w_next_state = S_IDLE;
        else if (r_idx == LAST_IDX) w_next_state = S_DONE;
        else                        w_next_state = S_SETTLE;
      end
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Vector index, settle counter, registered status and mismatch statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx             <= '0;
      r_cnt             <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_err_count       <= '0;
      r_err_flags       <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_idx   <= '0;
    end else begin
      r_busy <= (w_next_state == S_SETTLE) || (w_next_state == S_CHECK);
      r_done <= (w_next_state == S_DONE);

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_idx             <= '0;
            r_cnt             <= SETTLE_INIT;
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_err_flags       <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_idx   <= '0;
          end
        end

        S_SETTLE: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end

        S_CHECK: begin
          // The compare happens even when this cycle is being aborted.
          if (w_any_bad) begin
            if (r_err_count != ERR_MAX) r_err_count <= r_err_count + ERR_ONE;
            r_err_flags <= r_err_flags | {w_dknf_bad, w_ddnf_bad};
            if (!r_first_err_valid) begin
              r_first_err_valid <= 1'b1;
              r_first_err_idx   <= r_idx;
            end
          end
          // The last vector ends the sweep; idx never wraps.
          if (!i_abort && (r_idx != LAST_IDX)) begin
            r_idx <= r_idx + IDX_ONE;
            r_cnt <= SETTLE_INIT;
          end
        end

        S_DONE: begin
          r_pass <= (r_err_count == '0);
        end

        default: ;
      endcase
    end
  end

  assign bus.o_x          = r_idx;
  assign bus.o_tab_addr   = r_idx;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pass           = r_pass;
  assign o_err_count      = r_err_count;
  assign o_err_flags      = r_err_flags;
  assign o_first_err_valid = r_first_err_valid;
  assign o_first_err_idx  = r_first_err_idx;

endmodule

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Self-check sequencer for the 9-input / 4-output truth-table logic blocks. It drives every input vector in turn into both the DDNF and DKNF implementations and reads the golden output word from a synchronous table ROM. It compares both implementations against the golden word and accumulates mismatch statistics. It sits above the DDNF/DKNF instances and the table ROM; the on-chip equivalent of the sweep the simulation bench performs.

## Interface
Parameters:
- N_IN, 9, input vector width; the sweep covers 2^N_IN vectors.
- N_OUT, 4, output word width of each implementation and of the table.
- SETTLE, 1, wait cycles per vector before compare; legal range 1..15 (≥1 covers the ROM latency).

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1, system clock; all logic on posedge.
- rst, in, 1, synchronous active-high reset.
- i_start, in, 1, start sweep; sampled only in IDLE.
- i_abort, in, 1, abandon sweep; effective in SETTLE and CHECK.
- o_x, out, N_IN, vector driven to both DDNF and DKNF inputs.
- o_tab_addr, out, N_IN, table ROM address; always equals o_x.
- i_tab_data, in, N_OUT, ROM data for the address presented one cycle earlier.
- i_y_ddnf, in, N_OUT, DDNF output.
- i_y_dknf, in, N_OUT, DKNF output.
- o_busy, out, 1, high in SETTLE and CHECK.
- o_done, out, 1, one-cycle pulse when a full sweep completes.
- o_pass, out, 1, high after a completed sweep with zero mismatches.
- o_err_count, out, N_IN+1, number of vectors where either implementation mismatched; saturates at 2^N_IN.
- o_err_flags, out, 2, sticky: bit0 = a DDNF mismatch occurred; bit1 = a DKNF mismatch occurred.
- o_first_err_valid, out, 1, o_first_err_idx holds a captured mismatch.
- o_first_err_idx, out, N_IN, first vector index that mismatched.

## Operation
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE → SETTLE on i_start:
  - idx, o_x and o_tab_addr ← 0; settle counter ← SETTLE.
  - o_err_count, o_err_flags, o_first_err_valid, o_first_err_idx and o_pass clear to 0.
- SETTLE:
  - Counter decrements each cycle.
  - When the counter is 1, go to CHECK on the next cycle.
- CHECK (one cycle):
  - ddnf_bad = (i_y_ddnf != i_tab_data); dknf_bad = (i_y_dknf != i_tab_data).
  - If either is bad: o_err_count += 1, o_err_flags |= {dknf_bad, ddnf_bad}.
  - If either is bad and o_first_err_valid is 0: capture idx and set o_first_err_valid.
  - If idx == 2^N_IN−1, go to DONE. Otherwise idx += 1, o_x/o_tab_addr update, counter ← SETTLE, and return to SETTLE.
- DONE (one cycle):
  - o_done = 1; o_pass ← (o_err_count == 0).
  - Go to IDLE.
- Results persist in IDLE until the next accepted i_start.
- i_abort in SETTLE or CHECK:
  - Next state is IDLE. No o_done; o_pass stays 0.
  - Counters and flags keep their partial values.
  - The CHECK-cycle compare is still performed if abort arrives in CHECK.
- i_start while busy or in DONE is ignored; it is not queued.
- i_start and i_abort together in IDLE: start wins; abort is ignored in IDLE.
- Index wrap: idx never increments past 2^N_IN−1; the last vector terminates the sweep.

## Timing
- Reset values:
  - FSM = IDLE; o_x = o_tab_addr = 0.
  - o_busy, o_done, o_pass, o_err_count, o_err_flags, o_first_err_valid, o_first_err_idx = 0.
- Reset mid-sweep returns everything to its reset value on the next edge; no o_done.
- Per vector: SETTLE cycles in SETTLE plus 1 CHECK cycle.
- Full sweep: 2^N_IN·(SETTLE+1) cycles of o_busy. With defaults this is 1024 cycles.
- o_done asserts on the cycle after the final CHECK.
- o_x/o_tab_addr change only on the edge leaving CHECK or leaving IDLE. They are stable for the whole of SETTLE and CHECK.
- Compare uses i_tab_data and i_y_* sampled in the CHECK cycle. The ROM must be synchronous with 1-cycle read latency.
- Outputs are all registered; o_busy is registered from the FSM state.

## Test plan
- Golden DDNF/DKNF models, defaults, pulse i_start → o_busy high for exactly 1024 cycles, o_done pulse on the next cycle, o_pass=1, o_err_count=0, o_err_flags=2'b00, o_first_err_valid=0.
- DKNF model with bit 2 flipped at idx 9'h1A5 only → o_err_count=1, o_err_flags=2'b10, o_first_err_idx=9'h1A5, o_pass=0.
- DDNF model outputs constant 4'hF against a table containing no 4'hF entries → o_err_count=512 (10'h200), o_err_flags=2'b01, o_first_err_idx=0.
- SETTLE=3, golden models → sweep lasts 2048 busy cycles; o_x held 4 cycles per value.
- i_abort at idx=100 → back to IDLE, no o_done, o_pass=0. A later i_start restarts at idx 0 with cleared counters. An i_start pulsed mid-sweep has no effect on the sweep length.
- rst asserted at idx=300 → next cycle all outputs at reset values. Rerunning the sweep completes normally.
